// File: rtl/gearbox_pkg.sv
// Gearbox controller shared definitions: gear encodings and
// active-low 7-segment glyphs (bit 0 = segment a, bit 6 = segment g).
package gearbox_pkg;

  localparam int GEAR_R = 0;
  localparam int GEAR_N = 1;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_R     = 7'h2F;
  localparam logic [6:0] SEG_N     = 7'h2B;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [6:0] digit_glyph(input logic [3:0] d);
    logic [6:0] g;
    g = SEG_BLANK;
    case (d)
      4'd0: g = SEG_0;
      4'd1: g = SEG_1;
      4'd2: g = SEG_2;
      4'd3: g = SEG_3;
      4'd4: g = SEG_4;
      4'd5: g = SEG_5;
      4'd6: g = SEG_6;
      4'd7: g = SEG_7;
      4'd8: g = SEG_8;
      4'd9: g = SEG_9;
      default: g = SEG_BLANK;
    endcase
    return g;
  endfunction

  function automatic logic [6:0] gear_to_glyph(input logic [3:0] gc);
    logic [6:0] g;
    if (gc == 4'(GEAR_R))
      g = SEG_R;
    else if (gc == 4'(GEAR_N))
      g = SEG_N;
    else
      g = digit_glyph(gc - 4'd1);
    return g;
  endfunction

endpackage

// File: rtl/gearbox_ctrl_mux_button_conditioner.sv
// Raw button -> 2-FF synchroniser -> debounced level -> one-cycle rising pulse.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_btn,
  output logic o_level,
  output logic o_rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] C_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic          r_level;
  logic          r_level_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync    <= '0;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
    end else begin
      r_sync    <= {r_sync[0], i_btn};
      r_level_d <= r_level;
      // any sample equal to the accepted level restarts the run
      if (r_sync[1] == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == C_LAST) begin
        r_level <= r_sync[1];
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_level & ~r_level_d;

endmodule

// File: rtl/gearbox_ctrl_mux.sv
// Gearbox controller: button conditioning, gear FSM, brake timer, 4-digit scan.
// Optional reverse gear enabled by defining GEARBOX_REVERSE_EN.
module gearbox_ctrl_mux #(
  parameter int MAX_GEAR        = 5,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int SCAN_DIV        = 100_000,
  parameter int BRAKE_TICKS     = 25_000_000,
  localparam int GW             = $clog2(MAX_GEAR + 2)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          shift_up,
  input  logic          shift_down,
  input  logic          brake,
  output logic [GW-1:0] gear_code,
  output logic [6:0]    seg,
  output logic [3:0]    an
);

  import gearbox_pkg::*;

  localparam logic [GW-1:0] G_R   = GW'(GEAR_R);
  localparam logic [GW-1:0] G_N   = GW'(GEAR_N);
  localparam logic [GW-1:0] G_MAX = GW'(MAX_GEAR + 1);

  localparam int BW = $clog2(BRAKE_TICKS + 1);
  localparam logic [BW-1:0] B_LAST = BW'(BRAKE_TICKS - 1);
  localparam int SW = $clog2(SCAN_DIV + 1);
  localparam logic [SW-1:0] S_LAST = SW'(SCAN_DIV - 1);

  logic w_up_rise, w_dn_rise, w_brk_rise;
  logic w_up_lvl, w_dn_lvl, w_brk;
  logic w_up, w_dn, w_auto;
  logic [GW-1:0] w_gear_nxt;
  logic [6:0]    w_glyph;

  logic [GW-1:0] r_gear;
  logic [BW-1:0] r_brk_cnt;
  logic [3:0]    r_ones;
  logic [3:0]    r_tens;
  logic [SW-1:0] r_scan_cnt;
  logic [1:0]    r_scan_idx;
  logic [6:0]    r_seg;
  logic [3:0]    r_an;

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
    .clk(clk), .reset(reset), .i_btn(shift_up),
    .o_level(w_up_lvl), .o_rise(w_up_rise)
  );

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dn (
    .clk(clk), .reset(reset), .i_btn(shift_down),
    .o_level(w_dn_lvl), .o_rise(w_dn_rise)
  );

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_brk (
    .clk(clk), .reset(reset), .i_btn(brake),
    .o_level(w_brk), .o_rise(w_brk_rise)
  );

  assign w_up   = w_up_rise & ~w_dn_rise & ~w_brk;
  assign w_dn   = w_dn_rise & ~w_up_rise;
  assign w_auto = w_brk && (r_gear > G_N) && (r_brk_cnt == B_LAST);

  // auto and manual downshift in the same cycle merge into one step
  always_comb begin
    w_gear_nxt = r_gear;
    if (w_dn || w_auto) begin
      if (r_gear > G_N)
        w_gear_nxt = r_gear - GW'(1);
      else if (r_gear == G_R)
        w_gear_nxt = G_N;
`ifdef GEARBOX_REVERSE_EN
      else if (w_dn && w_brk)
        w_gear_nxt = G_R;
`endif
    end else if (w_up) begin
      if (r_gear != G_R && r_gear != G_MAX)
        w_gear_nxt = r_gear + GW'(1);
`ifdef GEARBOX_REVERSE_EN
      else if (r_gear == G_R)
        w_gear_nxt = G_N;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_gear    <= G_N;
      r_brk_cnt <= '0;
      r_ones    <= '0;
      r_tens    <= '0;
    end else begin
      r_gear <= w_gear_nxt;
      if (w_brk && (w_gear_nxt > G_N) && !w_auto)
        r_brk_cnt <= r_brk_cnt + BW'(1);
      else
        r_brk_cnt <= '0;
      if (w_gear_nxt != r_gear) begin
        if (r_ones == 4'd9) begin
          r_ones <= '0;
          r_tens <= (r_tens == 4'd9) ? 4'd0 : r_tens + 4'd1;
        end else begin
          r_ones <= r_ones + 4'd1;
        end
      end
    end
  end

  always_comb begin
    w_glyph = SEG_BLANK;
    unique case (r_scan_idx)
      2'd0: w_glyph = gear_to_glyph(4'(r_gear));
      2'd1: w_glyph = w_brk ? SEG_B : SEG_BLANK;
      2'd2: w_glyph = digit_glyph(r_ones);
      2'd3: w_glyph = digit_glyph(r_tens);
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_scan_cnt <= '0;
      r_scan_idx <= '0;
      r_an       <= 4'b1111;
      r_seg      <= SEG_BLANK;
    end else begin
      r_an  <= ~(4'b0001 << r_scan_idx);
      r_seg <= w_glyph;
      if (r_scan_cnt == S_LAST) begin
        r_scan_cnt <= '0;
        r_scan_idx <= r_scan_idx + 2'd1;
      end else begin
        r_scan_cnt <= r_scan_cnt + SW'(1);
      end
    end
  end

  assign gear_code = r_gear;
  assign seg       = r_seg;
  assign an        = r_an;

endmodule

// File: tb/tb_gearbox_ctrl_mux.sv
// Directed bench for gearbox_ctrl_mux with small sim parameters.
module tb_gearbox_ctrl_mux;

  logic       clk = 1'b0;
  logic       reset;
  logic       shift_up;
  logic       shift_down;
  logic       brake;
  logic [2:0] gear_code;
  logic [6:0] seg;
  logic [3:0] an;

  int n_pass = 0;
  int n_total = 0;

  localparam logic [6:0] E_R = 7'h2F;
  localparam logic [6:0] E_N = 7'h2B;
  localparam logic [6:0] E_B = 7'h03;
  localparam logic [6:0] E_BLANK = 7'h7F;

  gearbox_ctrl_mux #(
    .MAX_GEAR(3), .DEBOUNCE_CYCLES(4), .SCAN_DIV(4), .BRAKE_TICKS(8)
  ) dut (
    .clk(clk), .reset(reset), .shift_up(shift_up),
    .shift_down(shift_down), .brake(brake),
    .gear_code(gear_code), .seg(seg), .an(an)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic up;
    logic dn;
    int   len;
    int   gear;
    int   cnt;
  } vec_t;

  function automatic logic [6:0] exp_digit(input int d);
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic chk_digit(input string nm, input int idx, input logic [6:0] exp);
    logic [3:0] want;
    bit found;
    want = ~(4'b0001 << idx);
    found = 0;
    for (int k = 0; k < 24 && !found; k++) begin
      @(negedge clk);
      if (an == want) found = 1;
    end
    if (!found) begin
      n_total++;
      $display("FAIL %s: digit %0d never lit, an=%b", nm, idx, an);
    end else begin
      chk(nm, int'(seg), int'(exp));
    end
  endtask

  task automatic chk_count(input string nm, input int c);
    chk_digit({nm, "_units"}, 2, exp_digit(c % 10));
    chk_digit({nm, "_tens"}, 3, exp_digit(c / 10));
  endtask

  task automatic press(input logic u, input logic d, input int len);
    @(posedge clk); #1;
    shift_up = u;
    shift_down = d;
    repeat (len) @(posedge clk);
    #1;
    shift_up = 1'b0;
    shift_down = 1'b0;
    repeat (12) @(posedge clk);
    #1;
  endtask

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 8, 3, 2};
    vecs[1]  = '{1'b1, 1'b0, 8, 4, 3};
    vecs[2]  = '{1'b1, 1'b0, 8, 4, 3};
    vecs[3]  = '{1'b1, 1'b0, 2, 4, 3};
    vecs[4]  = '{1'b0, 1'b1, 8, 3, 4};
    vecs[5]  = '{1'b0, 1'b1, 8, 2, 5};
    vecs[6]  = '{1'b1, 1'b1, 8, 2, 5};
    vecs[7]  = '{1'b0, 1'b1, 8, 1, 6};
    vecs[8]  = '{1'b0, 1'b1, 8, 1, 6};
    vecs[9]  = '{1'b1, 1'b0, 8, 2, 7};
    vecs[10] = '{1'b1, 1'b0, 8, 3, 8};
    vecs[11] = '{1'b1, 1'b0, 8, 4, 9};

    reset = 1'b0;
    shift_up = 1'b0;
    shift_down = 1'b0;
    brake = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_an", int'(an), 15);
    chk("rst_seg", int'(seg), int'(E_BLANK));
    chk("rst_gear", int'(gear_code), 1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rel_an", int'(an), 4'b1110);
    chk("rel_seg", int'(seg), int'(E_N));

    // first press: exact press-to-change latency
    @(posedge clk); #1;
    shift_up = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk); #1;
      if (e == 6) chk("lat_e6", int'(gear_code), 1);
      if (e == 7) chk("lat_e7", int'(gear_code), 2);
    end
    shift_up = 1'b0;
    repeat (12) @(posedge clk);
    #1;

    for (int i = 0; i < 12; i++) begin
      press(vecs[i].up, vecs[i].dn, vecs[i].len);
      chk($sformatf("vec%0d_gear", i), int'(gear_code), vecs[i].gear);
      chk_count($sformatf("vec%0d_cnt", i), vecs[i].cnt);
    end

    // brake held at G3: auto-downshift every 8 cycles to N
    @(posedge clk); #1;
    brake = 1'b1;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk); #1;
      if (e == 13) chk("brk_e13", int'(gear_code), 4);
      if (e == 14) chk("brk_e14", int'(gear_code), 3);
      if (e == 21) chk("brk_e21", int'(gear_code), 3);
      if (e == 22) chk("brk_e22", int'(gear_code), 2);
      if (e == 29) chk("brk_e29", int'(gear_code), 2);
      if (e == 30) chk("brk_e30", int'(gear_code), 1);
      if (e == 40) chk("brk_e40", int'(gear_code), 1);
    end
    chk_digit("brk_digit1_b", 1, E_B);
    @(posedge clk); #1;
    brake = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk_digit("brk_digit1_blank", 1, E_BLANK);
    chk_count("brk_cnt", 12);

    // brake + down at N
    @(posedge clk); #1;
    brake = 1'b1;
    repeat (8) @(posedge clk);
    press(1'b0, 1'b1, 8);
`ifdef GEARBOX_REVERSE_EN
    chk("rev_gear", int'(gear_code), 0);
    chk_digit("rev_digit0", 0, E_R);
`else
    chk("rev_gear", int'(gear_code), 1);
    chk_digit("rev_digit0", 0, E_N);
`endif
    @(posedge clk); #1;
    brake = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    press(1'b1, 1'b0, 8);
`ifdef GEARBOX_REVERSE_EN
    chk("rev_up_gear", int'(gear_code), 1);
    chk_count("rev_up_cnt", 14);
`else
    chk("rev_up_gear", int'(gear_code), 2);
    chk_count("rev_up_cnt", 13);
`endif

    // reset mid-press discards the pending pulse
    @(posedge clk); #1;
    shift_up = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    shift_up = 1'b0;
    @(negedge clk);
    chk("mid_rst_gear", int'(gear_code), 1);
    chk("mid_rst_an", int'(an), 15);
    chk("mid_rst_seg", int'(seg), int'(E_BLANK));
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    chk("post_rst_gear", int'(gear_code), 1);
    chk_count("post_rst_cnt", 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
